// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART blocks: parity mode encodings, the
//   transmitter FSM state type and a small parity-mode helper.
// ----------------------------------------------------------------------------
package uart_pkg;

    // parity_mode encodings; 2'b11 is reserved and behaves as PAR_NONE
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // True when the mode inserts a parity bit into the frame
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock FIFO with registered storage and occupancy count. The head
//   word is visible on pop_data whenever empty is low (show-ahead).
//   Requests are guarded internally: a push while full or a pop while empty
//   is ignored. A full FIFO refuses a push even when a pop happens in the
//   same cycle, so full alone decides acceptance.
// Ports
//   clk       in   clock
//   reset     in   synchronous, active-high; flushes the FIFO
//   push      in   write request
//   push_data in   WIDTH  word to write
//   pop       in   read request (consumes the head word)
//   pop_data  out  WIDTH  head word
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  $clog2(DEPTH)+1  words stored
// ----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; count tells
    // full apart from empty when the pointers are equal.
    // NOTE: sequential state is always assigned with <= so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; stale entries are
    // unreachable once the pointers and count are cleared, and leaving the
    // array out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// ----------------------------------------------------------------------------
// uart_tx_stream
//   UART transmitter fed by a valid/ready port through an input FIFO.
//   Frames: start bit, DATA_BITS data bits LSB first, optional parity bit,
//   STOP_BITS stop bits; each bit lasts CLKS_PER_BIT clocks. Queued words
//   are sent back-to-back with no idle gap. tx is a register, so there is
//   no combinational path from the input port to the line.
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high; aborts any frame in flight
//   s_data       in   DATA_BITS  word to transmit
//   s_valid      in   s_data valid
//   s_ready      out  FIFO can accept (= !full)
//   parity_mode  in   2  00 none, 01 even, 10 odd, 11 none; latched per frame
//   tx           out  serial line, idle high
//   busy         out  frame in progress or FIFO non-empty
//   fifo_count   out  $clog2(FIFO_DEPTH)+1  words queued
// ----------------------------------------------------------------------------
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_BITS-1:0]         s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [1:0]                   parity_mode,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_stream: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_stream: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    // FIFO interface
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 frame_load;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s_valid),
        .push_data (s_data),
        .pop       (frame_load),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Transmit state
    tx_state_t            state,   state_next;
    logic                 tx_q,    tx_next;
    logic [CNT_W-1:0]     baud_q,  baud_next;
    logic [BIT_W-1:0]     bit_q,   bit_next;    // data index, then stop index
    logic [DATA_BITS-1:0] shift_q, shift_next;
    logic                 par_en_q,  par_en_next;
    logic                 par_bit_q, par_bit_next;
    logic                 baud_wrap;

    assign baud_wrap = (baud_q == LAST_TICK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            tx_q      <= 1'b1;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state     <= state_next;
            tx_q      <= tx_next;
            baud_q    <= baud_next;
            bit_q     <= bit_next;
            shift_q   <= shift_next;
            par_en_q  <= par_en_next;
            par_bit_q <= par_bit_next;
        end
    end

    // tx_next is the value the line takes for the next bit, so the line
    // changes on the same edge the FSM advances.
    // NOTE: every signal written here gets a default first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_next   = state;
        tx_next      = tx_q;
        baud_next    = baud_q;
        bit_next     = bit_q;
        shift_next   = shift_q;
        par_en_next  = par_en_q;
        par_bit_next = par_bit_q;
        frame_load   = 1'b0;

        if (state != ST_IDLE) begin
            baud_next = baud_wrap ? '0 : baud_q + CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                tx_next    = 1'b1;
                frame_load = !fifo_empty;
            end
            ST_START: begin
                if (baud_wrap) begin
                    state_next = ST_DATA;
                    bit_next   = '0;
                    tx_next    = shift_q[0];
                    shift_next = shift_q >> 1;
                end
            end
            ST_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == LAST_DATA) begin
                        bit_next = '0;
                        if (par_en_q) begin
                            state_next = ST_PARITY;
                            tx_next    = par_bit_q;
                        end else begin
                            state_next = ST_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next   = bit_q + BIT_W'(1);
                        tx_next    = shift_q[0];
                        shift_next = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_wrap) begin
                    state_next = ST_STOP;
                    bit_next   = '0;
                    tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_wrap) begin
                    if (bit_q == LAST_STOP) begin
                        // Chain straight into the next start bit when a word waits
                        if (!fifo_empty) frame_load = 1'b1;
                        else             state_next = ST_IDLE;
                    end else begin
                        bit_next = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Frame setup: pop the head word and freeze parity for this frame
        if (frame_load) begin
            state_next   = ST_START;
            tx_next      = 1'b0;
            baud_next    = '0;
            bit_next     = '0;
            shift_next   = fifo_head;
            par_en_next  = parity_enabled(parity_mode);
            par_bit_next = (parity_mode == PAR_ODD) ? ~^fifo_head : ^fifo_head;
        end
    end

    assign tx      = tx_q;
    assign s_ready = !fifo_full;
    assign busy    = (state != ST_IDLE) || (fifo_count != '0);

endmodule
